seq_mult_8bit: RTL and testbench

Sequential 8x8 unsigned shift-add multiplier producing a 16-bit product. It sits directly downstream of the team's 8-bit carry-lookahead adder and consumes that adder's sum and carry-out every iteration to build the partial product. It takes one operand pair per valid/ready transaction and returns the product on a held valid/ready output. It is the first multi-cycle arithmetic stage built on the CLA, and the template for later sequential datapaths.

---
 rtl/seq_mult_8bit_pkg.sv | 23 ++
 rtl/seq_mult_8bit_cla.sv | 44 ++++
 rtl/seq_mult_8bit.sv | 91 +++++++++
 tb/tb_seq_mult_8bit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seq_mult_8bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the state encoding, the datapath width and the iteration count.
package seq_mult_8bit_pkg;

  localparam int MULT_W    = 8;
  localparam int MULT_ITER = 8;
  localparam int CNT_W     = $clog2(MULT_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial-product term for one multiplier bit: the multiplicand or zero.
  function automatic logic [MULT_W-1:0] select_addend(
    input logic              bit0,
    input logic [MULT_W-1:0] mcand
  );
    return bit0 ? mcand : '0;
  endfunction

endpackage

// File: rtl/seq_mult_8bit_cla.sv
// 8-bit carry-lookahead adder built from two 4-bit lookahead groups.
// Used by the multiplier as its per-iteration adder.
module CLA_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [4:0] carryLo;
  logic [4:0] carryHi;
  logic [8:0] carry;

  // Every group carry is a flat sum of products of generate/propagate terms.
  function automatic logic [4:0] carries4(
    input logic [3:0] gIn,
    input logic [3:0] pIn,
    input logic       ci
  );
    logic [4:0] c;
    c[0] = ci;
    c[1] = gIn[0] | (pIn[0] & ci);
    c[2] = gIn[1] | (pIn[1] & gIn[0]) | (pIn[1] & pIn[0] & ci);
    c[3] = gIn[2] | (pIn[2] & gIn[1]) | (pIn[2] & pIn[1] & gIn[0])
         | (pIn[2] & pIn[1] & pIn[0] & ci);
    c[4] = gIn[3] | (pIn[3] & gIn[2]) | (pIn[3] & pIn[2] & gIn[1])
         | (pIn[3] & pIn[2] & pIn[1] & gIn[0]) | ((&pIn) & ci);
    return c;
  endfunction

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  assign carryLo = carries4(g[3:0], p[3:0], cin_i);
  assign carryHi = carries4(g[7:4], p[7:4], carryLo[4]);
  assign carry   = {carryHi, carryLo[3:0]};

  assign sum_o  = p ^ carry[7:0];
  assign cout_o = carry[8];

endmodule

// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-add multiplier with valid/ready handshakes.
// One multiplier bit is retired per BUSY cycle through the CLA adder.
module seq_mult_8bit
  import seq_mult_8bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MULT_W-1:0]     a,
  input  logic [MULT_W-1:0]     b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MULT_W-1:0]   product
);

  state_e            state_q, state_d;
  logic [MULT_W-1:0] mcand_q, mcand_d;
  logic [MULT_W-1:0] acc_hi_q, acc_hi_d;
  logic [MULT_W-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              lastIter;
  logic [MULT_W-1:0] addend;
  logic [MULT_W-1:0] sum;
  logic              carry;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign product   = {acc_hi_q, acc_lo_q};

  assign accept   = in_valid && in_ready;
  assign lastIter = (cnt_q == CNT_W'(MULT_ITER - 1));
  assign addend   = select_addend(acc_lo_q[0], mcand_q);

  CLA_8bit u_cla (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (lastIter)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The carry becomes the new MSB of the 17-bit shift, so a >= 0x80 stays exact.
  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    if (accept) begin
      mcand_d  = a;
      acc_hi_d = '0;
      acc_lo_d = b;
      cnt_d    = '0;
    end else if (state_q == BUSY) begin
      {acc_hi_d, acc_lo_d} = {carry, sum, acc_lo_q[MULT_W-1:1]};
      cnt_d                = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_8bit.sv
// Randomized self-checking bench for seq_mult_8bit against a plain a*b model.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_mult_8bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int errors = 0;
  int checks = 0;

  seq_mult_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full transaction: wait for in_ready, present operands, check latency,
  // hold out_ready low for 'stall' DONE cycles, then complete the transfer.
  task automatic applyStimulus(input logic [7:0] opA, input logic [7:0] opB,
                               input int stall, input string tag);
    int guard;
    int edges;
    bit readyLeaked;
    logic [15:0] expected;
    expected = 16'(opA) * 16'(opB);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput({tag, "_ready_timeout"}, 32'(guard), 32'd0);
    in_valid  = 1'b1;
    a         = opA;
    b         = opB;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    edges = 0;
    readyLeaked = 1'b0;
    while (!out_valid && edges < 40) begin
      if (in_ready) readyLeaked = 1'b1;
      @(negedge clk);
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'd8);
    checkOutput({tag, "_busy_in_ready"}, 32'(readyLeaked), 32'd0);
    checkOutput({tag, "_product"}, 32'(product), 32'(expected));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_product"}, 32'(product), 32'(expected));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] expQ[$];
  logic [15:0] expVal;
  bit          seenValid;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_product", 32'(product), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(8'h0D, 8'h0B, 0, "d_0d_0b");
    applyStimulus(8'hFF, 8'hFF, 0, "d_ff_ff");
    applyStimulus(8'h00, 8'hFF, 0, "d_00_ff");
    applyStimulus(8'hA5, 8'h00, 0, "d_a5_00");
    applyStimulus(8'h80, 8'h02, 5, "d_backpressure");
    applyStimulus(8'h81, 8'hC3, 1, "d_high_mcand");

    // Reset during BUSY once four iterations have completed.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midop_product", 32'(product), 32'd0);
    checkOutput("midop_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midop_in_ready", 32'(in_ready), 32'd1);
    seenValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seenValid = 1'b1;
      @(negedge clk);
    end
    checkOutput("midop_no_emit", 32'(seenValid), 32'd0);

    // Continuous in_valid: only operands presented while in_ready is high count.
    out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (out_valid) begin
        if (expQ.size() == 0) checkOutput("stream_unexpected", 32'd1, 32'd0);
        else begin
          expVal = expQ.pop_front();
          checkOutput("stream_product", 32'(product), 32'(expVal));
        end
      end
      a = 8'($urandom);
      b = 8'($urandom);
      in_valid = 1'b1;
      if (in_ready) expQ.push_back(16'(a) * 16'(b));
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 15 && expQ.size() > 0; i++) begin
      if (out_valid) begin
        expVal = expQ.pop_front();
        checkOutput("stream_product", 32'(product), 32'(expVal));
      end
      @(negedge clk);
    end
    checkOutput("stream_drained", 32'(expQ.size()), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 1000; n++)
      applyStimulus(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
